multicycle_ctrl: RTL and testbench

Moore-style FSM controller for the multicycle MIPS datapath. It sequences a single shared memory, ALU and register file across fetch/decode/execute/memory/writeback states for R-type, ADDI, ANDI, LW, SW, BEQ, BNE, J and JAL. It stalls on a memory ready handshake, latches the opcode, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style sequencer for a multicycle MIPS datapath.
// It drives one shared memory, the ALU and the register file through
// fetch/decode/execute/memory/writeback. It stalls on mem_ready, latches the
// opcode in DECODE, flags unsupported opcodes and counts retired instructions.
module multicycle_ctrl #(
   parameter int CNT_W = 32,
   parameter int OP_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  opcode,
   input  logic             mem_ready,
   output logic             pcWrite,
   output logic             pcWriteCond,
   output logic             pcWriteCondNe,
   output logic             iorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             irWrite,
   output logic [1:0]       memToReg,
   output logic [1:0]       regDst,
   output logic             regWrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic [1:0]       pcSrc,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state
);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_I_EXEC    = 4'd10;
   localparam logic [3:0] S_I_WB      = 4'd11;
   localparam logic [3:0] S_JAL       = 4'd12;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;

   logic [3:0]       state_q;
   logic [3:0]       next_st;
   logic [OP_W-1:0]  op_q;
   logic [CNT_W-1:0] retired_q;

   // Debug/count outputs read as zero while reset is held, like every other output.
   assign state   = rst ? 4'd0 : state_q;
   assign retired = rst ? '0 : retired_q;

   // State, latched opcode and retire counter; reset abandons any in-flight instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q <= next_st;
         if (state_q == S_DECODE)
            op_q <= opcode;
         if (instr_done)
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Next-state selection; memory states hold until mem_ready, unused codes recover to FETCH.
   always_comb begin
      next_st = S_FETCH;
      case (state_q)
         S_FETCH:     next_st = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_R:            next_st = S_R_EXEC;
               OP_ADDI, OP_ANDI: next_st = S_I_EXEC;
               OP_LW, OP_SW:    next_st = S_MEM_ADDR;
               OP_BEQ, OP_BNE:  next_st = S_BRANCH;
               OP_J:            next_st = S_JUMP;
               OP_JAL:          next_st = S_JAL;
               default:         next_st = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  next_st = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  next_st = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: next_st = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    next_st = S_R_WB;
         S_I_EXEC:    next_st = S_I_WB;
         default:     next_st = S_FETCH;
      endcase
   end

   // Moore output decode from state (plus op_q / mem_ready); all zero under reset.
   always_comb begin
      pcWrite       = 1'b0;
      pcWriteCond   = 1'b0;
      pcWriteCondNe = 1'b0;
      iorD          = 1'b0;
      memRead       = 1'b0;
      memWrite      = 1'b0;
      irWrite       = 1'b0;
      memToReg      = 2'b00;
      regDst        = 2'b00;
      regWrite      = 1'b0;
      aluSrcA       = 1'b0;
      aluSrcB       = 2'b00;
      aluOp         = 2'b00;
      pcSrc         = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               memRead = 1'b1;
               aluSrcB = 2'b01;
               irWrite = mem_ready;
               pcWrite = mem_ready;
            end
            S_DECODE: begin
               aluSrcB = 2'b11;
               case (opcode)
                  OP_R, OP_ADDI, OP_ANDI, OP_LW, OP_SW,
                  OP_BEQ, OP_BNE, OP_J, OP_JAL: illegal_op = 1'b0;
                  default:                      illegal_op = 1'b1;
               endcase
            end
            S_MEM_ADDR: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
               memRead = 1'b1;
               iorD    = 1'b1;
            end
            S_MEM_WB: begin
               regWrite   = 1'b1;
               memToReg   = 2'b01;
               instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
               memWrite   = 1'b1;
               iorD       = 1'b1;
               instr_done = mem_ready;
            end
            S_R_EXEC: begin
               aluSrcA = 1'b1;
               aluOp   = 2'b10;
            end
            S_R_WB: begin
               regWrite   = 1'b1;
               regDst     = 2'b01;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               aluSrcA       = 1'b1;
               aluOp         = 2'b01;
               pcSrc         = 2'b01;
               pcWriteCond   = (op_q == OP_BEQ);
               pcWriteCondNe = (op_q == OP_BNE);
               instr_done    = 1'b1;
            end
            S_JUMP: begin
               pcWrite    = 1'b1;
               pcSrc      = 2'b10;
               instr_done = 1'b1;
            end
            S_I_EXEC: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               aluOp   = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
            end
            S_I_WB: begin
               regWrite   = 1'b1;
               instr_done = 1'b1;
            end
            S_JAL: begin
               pcWrite    = 1'b1;
               pcSrc      = 2'b10;
               regWrite   = 1'b1;
               regDst     = 2'b10;
               memToReg   = 2'b10;
               instr_done = 1'b1;
            end
            default: pcWrite = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized bench for multicycle_ctrl. The reference model
// expands each instruction into its expected cycle-by-cycle state walk and
// control activity from the instruction class, fetch/memory wait counts and
// opcode, and keeps an integer retired count.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   logic clk = 1'b0;
   logic rst;
   logic [5:0] opcode;
   logic mem_ready;

   logic pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite;
   logic [1:0] memToReg, regDst, aluSrcB, aluOp, pcSrc;
   logic regWrite, aluSrcA, instr_done, illegal_op;
   logic [31:0] retired;
   logic [3:0] state;

   logic pcWrite4, pcWriteCond4, pcWriteCondNe4, iorD4, memRead4, memWrite4, irWrite4;
   logic [1:0] memToReg4, regDst4, aluSrcB4, aluOp4, pcSrc4;
   logic regWrite4, aluSrcA4, instr_done4, illegal_op4;
   logic [3:0] retired4;
   logic [3:0] state4;

   int checks = 0;
   int failures = 0;
   int unsigned ret_model = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32), .OP_W(6)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcWriteCondNe(pcWriteCondNe),
      .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
      .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA),
      .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc), .instr_done(instr_done),
      .illegal_op(illegal_op), .retired(retired), .state(state)
   );

   multicycle_ctrl #(.CNT_W(4), .OP_W(6)) dut4 (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pcWrite(pcWrite4), .pcWriteCond(pcWriteCond4), .pcWriteCondNe(pcWriteCondNe4),
      .iorD(iorD4), .memRead(memRead4), .memWrite(memWrite4), .irWrite(irWrite4),
      .memToReg(memToReg4), .regDst(regDst4), .regWrite(regWrite4), .aluSrcA(aluSrcA4),
      .aluSrcB(aluSrcB4), .aluOp(aluOp4), .pcSrc(pcSrc4), .instr_done(instr_done4),
      .illegal_op(illegal_op4), .retired(retired4), .state(state4)
   );

   function automatic bit is_legal(input logic [5:0] o);
      return (o == OP_R) || (o == OP_ADDI) || (o == OP_ANDI) || (o == OP_LW) ||
             (o == OP_SW) || (o == OP_BEQ) || (o == OP_BNE) || (o == OP_J) || (o == OP_JAL);
   endfunction

   // Hold reset for one edge with memory not ready, so the DUT sits in FETCH afterwards.
   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      opcode = 6'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      ret_model = 0;
   endtask

   // Run one instruction: fw fetch wait cycles, mw memory wait cycles (LW/SW).
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      logic [3:0] es[$];
      bit legal, wr, memop;
      int last, rdy;
      logic [12:0] got, want;
      logic [3:0] wb_want;
      legal = is_legal(op);
      memop = (op == OP_LW) || (op == OP_SW);
      wr = (op == OP_R) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_LW) || (op == OP_JAL);
      for (int k = 0; k <= fw; k++) es.push_back(4'd0);
      es.push_back(4'd1);
      case (op)
         OP_R:             begin es.push_back(4'd6); es.push_back(4'd7); end
         OP_ADDI, OP_ANDI: begin es.push_back(4'd10); es.push_back(4'd11); end
         OP_LW: begin
            es.push_back(4'd2);
            for (int k = 0; k <= mw; k++) es.push_back(4'd3);
            es.push_back(4'd4);
         end
         OP_SW: begin
            es.push_back(4'd2);
            for (int k = 0; k <= mw; k++) es.push_back(4'd5);
         end
         OP_BEQ, OP_BNE: es.push_back(4'd8);
         OP_J:           es.push_back(4'd9);
         OP_JAL:         es.push_back(4'd12);
         default:        ;
      endcase
      last = es.size() - 1;
      rdy = fw + 3 + mw;
      for (int i = 0; i <= last; i++) begin
         if (i < fw) mem_ready = 1'b0;
         else if (i == fw) mem_ready = 1'b1;
         else if (memop && i >= fw + 3 && i < rdy) mem_ready = 1'b0;
         else if (memop && i == rdy) mem_ready = 1'b1;
         else mem_ready = 1'($urandom_range(0, 1));
         opcode = (i == fw + 1) ? op : 6'($urandom);
         @(negedge clk);
         got = {state, instr_done, illegal_op, irWrite, memRead, memWrite, regWrite,
                pcWrite, pcWriteCond, pcWriteCondNe};
         want = {es[i], legal && (i == last), !legal && (i == last), i == fw,
                 (i <= fw) || (op == OP_LW && i >= fw + 3 && i <= rdy),
                 op == OP_SW && i >= fw + 3,
                 wr && (i == last),
                 (i == fw) || ((op == OP_J || op == OP_JAL) && i == last),
                 op == OP_BEQ && i == fw + 2,
                 op == OP_BNE && i == fw + 2};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL cycle op=%b cyc=%0d: got {st,done,ill,ir,mr,mw,rw,pw,pwc,pwcn}=%b want %b",
                     op, i, got, want);
         end
         if (i <= fw) begin
            checks++;
            if ({iorD, aluSrcA, aluSrcB, aluOp, pcSrc} !== 8'b00_01_00_00) begin
               failures++;
               $display("FAIL fetch_mux cyc=%0d: got %b want 00010000", i,
                        {iorD, aluSrcA, aluSrcB, aluOp, pcSrc});
            end
         end
         if (i == fw + 2 && (op == OP_ADDI || op == OP_ANDI)) begin
            checks++;
            if (aluOp !== ((op == OP_ANDI) ? 2'b11 : 2'b00)) begin
               failures++;
               $display("FAIL i_exec_aluop op=%b: got %b", op, aluOp);
            end
         end
         if (wr && i == last) begin
            case (op)
               OP_R:    wb_want = 4'b01_00;
               OP_LW:   wb_want = 4'b00_01;
               OP_JAL:  wb_want = 4'b10_10;
               default: wb_want = 4'b00_00;
            endcase
            checks++;
            if ({regDst, memToReg} !== wb_want) begin
               failures++;
               $display("FAIL wb_sel op=%b: got regDst,memToReg=%b want %b", op,
                        {regDst, memToReg}, wb_want);
            end
         end
         @(posedge clk); #1;
      end
      if (legal) ret_model++;
      checks++;
      if (retired !== ret_model || retired4 !== 4'(ret_model)) begin
         failures++;
         $display("FAIL retired op=%b: got %0d/%0d want %0d/%0d", op, retired, retired4,
                  ret_model, ret_model % 16);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_ready = 1'b1;
      opcode = OP_SW;
      @(negedge clk);
      checks++;
      if ({pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite, memToReg,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, instr_done, illegal_op,
           retired, state} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: outputs not all zero, memRead=%b state=%0d", memRead, state);
      end
      do_reset();
      @(negedge clk);
      checks++;
      if ({state, retired, memRead} !== {4'd0, 32'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_release: state=%0d retired=%0d memRead=%b want 0 0 1",
                  state, retired, memRead);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_write();
      run_instr(OP_J, 0, 0);
      run_instr(OP_R, 1, 0);
      mem_ready = 1'b1; opcode = 6'd0;   @(posedge clk); #1;
      mem_ready = 1'b0; opcode = OP_SW;  @(posedge clk); #1;
      opcode = 6'd0;                     @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({state, memWrite} !== {4'd5, 1'b1}) begin
         failures++;
         $display("FAIL sw_enter: state=%0d memWrite=%b want 5 1", state, memWrite);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({memWrite, iorD, state} !== 6'd0) begin
         failures++;
         $display("FAIL reset_mid_write: memWrite=%b iorD=%b state=%0d want 0", memWrite, iorD, state);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      ret_model = 0;
      @(negedge clk);
      checks++;
      if ({state, retired, retired4, memRead} !== {4'd0, 32'd0, 4'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_abandon: state=%0d retired=%0d memRead=%b want 0 0 1",
                  state, retired, memRead);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_wait_seq();
      logic [5:0] seq[6];
      seq = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL};
      do_reset();
      foreach (seq[k]) run_instr(seq[k], 0, 0);
      checks++;
      if (retired !== 32'd6) begin
         failures++;
         $display("FAIL seq_retired: got %0d want 6", retired);
      end
   endtask

   task automatic test_stalls();
      run_instr(OP_LW, 2, 3);
      run_instr(OP_SW, 3, 2);
   endtask

   task automatic test_imm_and_illegal();
      run_instr(OP_ADDI, 0, 0);
      run_instr(OP_ANDI, 1, 0);
      run_instr(6'b111111, 0, 0);
      run_instr(OP_BNE, 0, 0);
      run_instr(6'b010101, 2, 0);
   endtask

   task automatic test_random();
      logic [5:0] ops[9];
      logic [5:0] op;
      ops = '{OP_R, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom);
            while (is_legal(op)) op = 6'($urandom);
         end else begin
            op = ops[$urandom_range(0, 8)];
         end
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int n = 0; n < 17; n++) run_instr(OP_J, 0, 0);
      checks++;
      if (retired4 !== 4'd1 || retired !== 32'd17) begin
         failures++;
         $display("FAIL counter_wrap: got %0d (CNT_W=4) %0d (CNT_W=32) want 1 17", retired4, retired);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_write();
      test_zero_wait_seq();
      test_stalls();
      test_imm_and_illegal();
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
